// File: rtl/bus_bridge.sv
// bus_bridge: decodes the CPU data bus into DRAM and memory-mapped peripherals.
// Peripherals: seven-segment scanner, LED register, synchronized switches and buttons,
// and an optional timer that is built only when macro BRIDGE_TIMER_EN is defined.
module bus_bridge #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_we,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_we,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [19:0] PERIPH_PAGE = 20'hFFFFF;
    localparam logic [11:0] OFF_SEG     = 12'h000;
    localparam logic [11:0] OFF_CNT     = 12'h020;
    localparam logic [11:0] OFF_DIV     = 12'h024;
    localparam logic [11:0] OFF_LED     = 12'h060;
    localparam logic [11:0] OFF_SW      = 12'h070;
    localparam logic [11:0] OFF_BTN     = 12'h078;

    // Hex glyphs for an active-low {dp,g,f,e,d,c,b,a} display, dp held off.
    function automatic logic [7:0] hex_font(input logic [3:0] v);
        logic [7:0] f;
        case (v)
            4'h0: f = 8'hC0;
            4'h1: f = 8'hF9;
            4'h2: f = 8'hA4;
            4'h3: f = 8'hB0;
            4'h4: f = 8'h99;
            4'h5: f = 8'h92;
            4'h6: f = 8'h82;
            4'h7: f = 8'hF8;
            4'h8: f = 8'h80;
            4'h9: f = 8'h90;
            4'hA: f = 8'h88;
            4'hB: f = 8'h83;
            4'hC: f = 8'hC6;
            4'hD: f = 8'hA1;
            4'hE: f = 8'h86;
            default: f = 8'h8E;
        endcase
        return f;
    endfunction

    logic        periph;
    logic [11:0] off;
    logic        periph_we;

    logic [31:0] seg_data;
    logic [31:0] led_reg;
    logic [31:0] timer_count;
    logic [31:0] timer_div;
    logic [23:0] sw_meta;
    logic [23:0] sw_sync;
    logic [4:0]  btn_meta;
    logic [4:0]  btn_sync;

    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit;
    logic [2:0]        digit_next;
    logic [3:0]        nibble_next;
    logic              scan_wrap;

    assign periph    = (Bus_addr[31:12] == PERIPH_PAGE);
    assign off       = Bus_addr[11:0];
    assign periph_we = Bus_we & periph;

    // DRAM side is a pure pass-through, never gated by reset.
    assign dram_addr  = Bus_addr[15:2];
    assign dram_we    = Bus_we & ~periph;
    assign dram_wdata = Bus_wdata;

    assign led = led_reg[23:0];

    // CPU-writable display and LED registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            seg_data <= '0;
            led_reg  <= '0;
        end else if (periph_we) begin
            if (off == OFF_SEG) seg_data <= Bus_wdata;
            if (off == OFF_LED) led_reg  <= Bus_wdata;
        end
    end

    // Two-flop synchronizers for the asynchronous switches and buttons.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= button;
            btn_sync <= btn_meta;
        end
    end

    assign scan_wrap   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign digit_next  = digit + 3'd1;
    assign nibble_next = 4'(seg_data >> {digit_next, 2'b00});

    // Display scanner; the glyph is latched when a digit is refreshed so new data
    // appears at the next refresh without disturbing the scan phase.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            scan_cnt <= '0;
            digit    <= 3'd0;
            dig_en   <= 8'hFE;
            seg      <= 8'hC0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            digit    <= digit_next;
            dig_en   <= ~(8'd1 << digit_next);
            seg      <= hex_font(nibble_next);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

`ifdef BRIDGE_TIMER_EN
    logic [31:0] timer_pre;
    logic        tick;

    assign tick = (timer_div != 32'd0) && (timer_pre >= timer_div - 32'd1);

    // Divisor register and prescaler; a divisor write restarts the prescale period.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            timer_div <= '0;
            timer_pre <= '0;
        end else if (periph_we && (off == OFF_DIV)) begin
            timer_div <= Bus_wdata;
            timer_pre <= '0;
        end else if (tick || (timer_div == 32'd0)) begin
            timer_pre <= '0;
        end else begin
            timer_pre <= timer_pre + 32'd1;
        end
    end

    // Count register; a CPU write takes priority over a coincident tick.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            timer_count <= '0;
        end else if (periph_we && (off == OFF_CNT)) begin
            timer_count <= Bus_wdata;
        end else if (tick) begin
            timer_count <= timer_count + 32'd1;
        end
    end
`else
    assign timer_count = '0;
    assign timer_div   = '0;
`endif

    // Same-cycle read mux.
    always_comb begin
        Bus_rdata = '0;
        if (!periph) begin
            Bus_rdata = dram_rdata;
        end else begin
            case (off)
                OFF_SEG: Bus_rdata = seg_data;
                OFF_CNT: Bus_rdata = timer_count;
                OFF_DIV: Bus_rdata = timer_div;
                OFF_LED: Bus_rdata = led_reg;
                OFF_SW:  Bus_rdata = {8'h00, sw_sync};
                OFF_BTN: Bus_rdata = {27'h0, btn_sync};
                default: Bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge.sv
// tb_bus_bridge: scoreboard bench for bus_bridge. The driver queues expected values,
// a negedge monitor pops and compares them. Timer expectations follow BRIDGE_TIMER_EN.
`timescale 1ns/1ps
module tb_bus_bridge;

    localparam int unsigned SCAN_DIV = 4;

    localparam logic [31:0] A_SEG = 32'hFFFFF000;
    localparam logic [31:0] A_CNT = 32'hFFFFF020;
    localparam logic [31:0] A_DIV = 32'hFFFFF024;
    localparam logic [31:0] A_LED = 32'hFFFFF060;
    localparam logic [31:0] A_SW  = 32'hFFFFF070;
    localparam logic [31:0] A_BTN = 32'hFFFFF078;

`ifdef BRIDGE_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam int K_RDATA  = 0;
    localparam int K_LED    = 1;
    localparam int K_DIGEN  = 2;
    localparam int K_SEG    = 3;
    localparam int K_DWE    = 4;
    localparam int K_DADDR  = 5;
    localparam int K_DWDATA = 6;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_we;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    bus_bridge #(.SCAN_DIV(SCAN_DIV)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_we     (Bus_we),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .seg        (seg)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // DRAM stand-in driven only by the DUT's dram_* pins.
    logic [31:0] dram_mem [0:16383];
    assign dram_rdata = dram_mem[dram_addr];
    always @(posedge cpu_clk) if (dram_we) dram_mem[dram_addr] <= dram_wdata;

    // Edges since the last reset release.
    int cyc;
    always @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:16383];
    bit          written [0:16383];
    logic [31:0] m_seg;
    logic [31:0] m_led;
    logic [23:0] m_sw;
    logic [4:0]  m_btn;
    int          seg_edge[$];
    logic [31:0] seg_val[$];
    logic [7:0]  font_tb [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [31:0] ign_addr [8] = '{32'hFFFFF070, 32'hFFFFF078, 32'hFFFFF004, 32'hFFFFF030,
                                  32'hFFFFF100, 32'hFFFFFFFC, 32'hFFFFF074, 32'hFFFFF064};
    logic [31:0] rd_addr [6]  = '{32'hFFFFF000, 32'hFFFFF060, 32'hFFFFF070, 32'hFFFFF078,
                                  32'hFFFFF020, 32'hFFFFF024};

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sbq[$];
    bit   sample;
    int   total;
    int   bad;

    function automatic string kname(input int k);
        case (k)
            K_RDATA:  return "rdata";
            K_LED:    return "led";
            K_DIGEN:  return "dig_en";
            K_SEG:    return "seg";
            K_DWE:    return "dram_we";
            K_DADDR:  return "dram_addr";
            default:  return "dram_wdata";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RDATA:  return Bus_rdata;
            K_LED:    return {8'h00, led};
            K_DIGEN:  return {24'h0, dig_en};
            K_SEG:    return {24'h0, seg};
            K_DWE:    return {31'h0, dram_we};
            K_DADDR:  return {18'h0, dram_addr};
            default:  return dram_wdata;
        endcase
    endfunction

    // Monitor: compares every queued expectation whenever the driver presents a sample point.
    always @(negedge cpu_clk) begin
        if (sample) begin
            while (sbq.size() > 0) begin
                chk_t        c;
                logic [31:0] a;
                c = sbq.pop_front();
                a = actual(c.kind);
                total++;
                if (a !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h at t=%0t", kname(c.kind), a, c.exp, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic sb_push(input int k, input logic [31:0] v);
        chk_t c;
        c.kind = k;
        c.exp  = v;
        sbq.push_back(c);
    endtask

    task automatic strobe();
        sample = 1'b1;
        @(negedge cpu_clk);
        #1 sample = 1'b0;
    endtask

    function automatic logic [31:0] te(input logic [31:0] v);
        return TIMER_EN ? v : 32'h0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr[31:12] != 20'hFFFFF) return ref_mem[addr[15:2]];
        case (addr[11:0])
            12'h000: return m_seg;
            12'h060: return m_led;
            12'h070: return {8'h00, m_sw};
            12'h078: return {27'h0, m_btn};
            default: return 32'h0;
        endcase
    endfunction

    // Seg data as seen by a refresh at edge m: the latest write strictly before m.
    function automatic logic [31:0] seg_at(input int m);
        logic [31:0] v;
        v = 32'h0;
        for (int j = 0; j < seg_edge.size(); j++) if (seg_edge[j] < m) v = seg_val[j];
        return v;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bit is_p;
        is_p      = (addr[31:12] == 20'hFFFFF);
        Bus_addr  = addr;
        Bus_we    = 1'b1;
        Bus_wdata = data;
        sb_push(K_DWE, is_p ? 32'h0 : 32'h1);
        if (!is_p) begin
            sb_push(K_DADDR, {18'h0, addr[15:2]});
            sb_push(K_DWDATA, data);
        end
        sb_push(K_LED, {8'h00, m_led[23:0]});
        strobe();
        @(posedge cpu_clk);
        #1;
        Bus_we = 1'b0;
        if (!is_p) begin
            ref_mem[addr[15:2]] = data;
            written[addr[15:2]] = 1'b1;
        end else if (addr[11:0] == 12'h000) begin
            m_seg = data;
            seg_edge.push_back(cyc);
            seg_val.push_back(data);
        end else if (addr[11:0] == 12'h060) begin
            m_led = data;
        end
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        Bus_addr = addr;
        Bus_we   = 1'b0;
        sb_push(K_RDATA, exp);
        if (addr[31:12] != 20'hFFFFF) sb_push(K_DADDR, {18'h0, addr[15:2]});
        sb_push(K_LED, {8'h00, m_led[23:0]});
        strobe();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            Bus_we = 1'b0;
            sb_push(K_LED, {8'h00, m_led[23:0]});
            strobe();
            @(posedge cpu_clk);
            #1;
        end
    endtask

    // Digit index and glyph derived from elapsed cycles since reset release.
    task automatic check_display(input int n);
        for (int i = 0; i < n; i++) begin
            int          idx;
            int          m;
            logic [7:0]  de;
            logic [31:0] v;
            logic [3:0]  nib;
            idx = (cyc / SCAN_DIV) % 8;
            m   = (cyc / SCAN_DIV) * SCAN_DIV;
            de  = 8'd1 << idx;
            de  = ~de;
            v   = seg_at(m);
            nib = 4'(v >> (4 * idx));
            Bus_we = 1'b0;
            sb_push(K_DIGEN, {24'h0, de});
            sb_push(K_SEG, {24'h0, font_tb[nib]});
            strobe();
            @(posedge cpu_clk);
            #1;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        sample    = 1'b0;
        cpu_rst   = 1'b1;
        Bus_addr  = A_SEG;
        Bus_we    = 1'b0;
        Bus_wdata = 32'h0;
        m_seg     = 32'h0;
        m_led     = 32'h0;
        m_sw      = 24'($urandom);
        m_btn     = 5'($urandom);
        sw        = m_sw;
        button    = m_btn;

        // Reset values.
        @(posedge cpu_clk);
        #1;
        sb_push(K_RDATA, 32'h0);
        sb_push(K_LED, 32'h0);
        sb_push(K_DIGEN, 32'hFE);
        sb_push(K_SEG, 32'hC0);
        strobe();
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        idle(3);

        // DRAM write then read-back.
        bus_write(32'h00000010, 32'h12345678);
        bus_read(32'h00000010, 32'h12345678);

        // LED write, visible next cycle, read-back.
        bus_write(A_LED, 32'h00ABCDEF);
        bus_read(A_LED, 32'h00ABCDEF);

        // Synchronizer latency on switches and buttons.
        begin
            logic [23:0] old_sw;
            logic [4:0]  old_btn;
            old_sw  = m_sw;
            old_btn = m_btn;
            sw      = 24'h00F00F;
            button  = ~old_btn;
            bus_read(A_SW, {8'h00, old_sw});
            bus_read(A_BTN, {27'h0, old_btn});
            bus_read(A_SW, {8'h00, 24'h00F00F});
            bus_read(A_BTN, {27'h0, ~old_btn});
            m_sw  = 24'h00F00F;
            m_btn = ~old_btn;
        end

        // Randomized bus traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int unsigned op;
            int unsigned idx;
            int unsigned hi;
            logic [31:0] a;
            logic [31:0] d;
            op  = $urandom_range(0, 6);
            idx = $urandom_range(0, 15);
            hi  = $urandom_range(0, 32'h0000FFFE);
            d   = $urandom;
            a   = {16'(hi), 14'(idx), 2'b00};
            case (op)
                0: bus_write(a, d);
                1: if (written[a[15:2]]) bus_read(a, ref_mem[a[15:2]]);
                   else bus_write(a, d);
                2: bus_write(A_SEG, d);
                3: bus_write(A_LED, d);
                4: bus_write(ign_addr[idx % 8], d);
                5: begin a = rd_addr[idx % 6]; bus_read(a, model_read(a)); end
                default: begin a = ign_addr[idx % 8]; bus_read(a, model_read(a)); end
            endcase
        end

        // Display scan with digit 0 showing 'A'.
        bus_write(A_SEG, 32'h0000000A);
        check_display(40);

        // Mid-digit update shows only from the next refresh.
        while ((cyc % SCAN_DIV) != 1) idle(1);
        bus_write(A_SEG, 32'hBBBBBBBB);
        check_display(12);

        // Timer: freeze, periodic increment, wrap, write-wins-over-tick.
        bus_write(A_DIV, 32'h0);
        bus_write(A_CNT, 32'h5);
        for (int k = 0; k < 3; k++) bus_read(A_CNT, te(32'h5));
        bus_read(A_DIV, te(32'h0));
        bus_write(A_DIV, 32'h3);
        for (int k = 0; k < 7; k++) bus_read(A_CNT, te(32'h5 + 32'(k / 3)));
        bus_write(A_DIV, 32'h0);
        bus_write(A_CNT, 32'hFFFFFFFF);
        bus_write(A_DIV, 32'h3);
        for (int k = 0; k < 5; k++) bus_read(A_CNT, te(32'hFFFFFFFF + 32'(k / 3)));
        bus_write(A_CNT, 32'h100);
        for (int k = 0; k < 5; k++) bus_read(A_CNT, te(32'h100 + 32'(k / 3)));
        bus_read(A_DIV, te(32'h3));

        // Reset asserted mid-scan and mid-timer.
        bus_write(A_LED, 32'h00FFFFFF);
        idle(2);
        #2;
        cpu_rst  = 1'b1;
        Bus_we   = 1'b0;
        Bus_addr = A_CNT;
        sb_push(K_RDATA, 32'h0);
        sb_push(K_LED, 32'h0);
        sb_push(K_DIGEN, 32'hFE);
        sb_push(K_SEG, 32'hC0);
        strobe();
        Bus_addr = A_SEG;
        sb_push(K_RDATA, 32'h0);
        sb_push(K_DIGEN, 32'hFE);
        strobe();
        @(posedge cpu_clk);
        #1;
        Bus_addr = A_LED;
        sb_push(K_RDATA, 32'h0);
        sb_push(K_SEG, 32'hC0);
        strobe();
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        m_seg   = 32'h0;
        m_led   = 32'h0;
        seg_edge.delete();
        seg_val.delete();

        bus_read(A_SW, 32'h0);
        bus_read(A_SW, 32'h0);
        bus_read(A_SW, {8'h00, m_sw});
        check_display(12);
        for (int k = 0; k < 3; k++) bus_read(A_CNT, 32'h0);
        bus_read(A_DIV, 32'h0);

        idle(2);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, cycles each seven-segment digit is held active.
REQ-002 SHALL have port cpu_clk, input, 1, single clock, rising-edge.
REQ-003 SHALL have port cpu_rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port Bus_addr, input, 32, CPU data address (MEM stage).
REQ-005 SHALL have port Bus_we, input, 1, CPU write strobe.
REQ-006 SHALL have port Bus_wdata, input, 32, CPU write data.
REQ-007 SHALL have port Bus_rdata, output, 32, read data to CPU.
REQ-008 SHALL have port dram_addr, output, 14, word address, equal to Bus_addr[15:2].
REQ-009 SHALL have port dram_we, output, 1, DRAM write enable.
REQ-010 SHALL have port dram_wdata, output, 32, equal to Bus_wdata.
REQ-011 SHALL have port dram_rdata, input, 32, DRAM read data.
REQ-012 SHALL have port sw, input, 24, asynchronous switches.
REQ-013 SHALL have port button, input, 5, asynchronous push-buttons.
REQ-014 SHALL have port led, output, 24, LED drive, active-high.
REQ-015 SHALL have port dig_en, output, 8, digit enables, active-low.
REQ-016 SHALL have port seg, output, 8, segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-017 SHALL decode a peripheral access when Bus_addr[31:12]==20'hFFFFF; every other address is a DRAM access.
REQ-018 SHALL use this map: 0xFFFFF000 seg data (R/W), 0xFFFFF020 timer count (R/W), 0xFFFFF024 timer divisor (R/W), 0xFFFFF060 LED (R/W), 0xFFFFF070 switches (RO), 0xFFFFF078 buttons (RO, bits [4:0]).
REQ-019 SHALL assert dram_we = Bus_we only for DRAM accesses; it SHALL be 0 for peripheral accesses.
REQ-020 SHALL drive Bus_rdata combinationally in the same cycle: dram_rdata for DRAM, the selected register for a mapped address, 0 for an unmapped peripheral address.
REQ-021 SHALL update peripheral registers on the rising cpu_clk edge when Bus_we=1; writes to read-only or unmapped addresses SHALL be ignored.
REQ-022 SHALL pass sw and button through a 2-flop synchronizer; the read value SHALL lag the pins by 2 cycles and be zero-extended.
REQ-023 SHALL drive led from the LED register bits [23:0].
REQ-024 SHALL scan the display with a SCAN_DIV-cycle prescaler and a 3-bit digit index 0..7 that wraps 7->0; exactly one dig_en bit SHALL be low at any time.
REQ-025 SHALL show seg-data nibble [4i+3:4i] on digit i (dig_en[i]=0) in standard hex font 0-F, with dp always off (1).
REQ-026 SHALL reflect a seg-data write on the display at the next digit refresh, without restarting the scan.
REQ-027 SHALL have the timer prescaler count 0..divisor-1 and increment the count register by 1 when the prescaler wraps; divisor==0 SHALL freeze the count and hold the prescaler at 0.
REQ-028 SHALL wrap the timer count from 0xFFFFFFFF to 0.
REQ-029 SHALL, on a CPU write to the count in the same cycle as a tick, store the written value (the write wins).
REQ-030 SHALL clear the prescaler when the divisor is written.

Reset
REQ-031 SHALL, on cpu_rst high, immediately clear the seg data, LED, timer count, divisor, prescalers, digit index and synchronizers; this gives led=0, dig_en=8'hFE, seg=8'hC0 (digit 0 showing "0").
REQ-032 SHALL hold all registers at reset value while cpu_rst=1, and scanning SHALL restart from digit 0 after deassertion.
REQ-033 SHALL NOT reset DRAM contents; dram_* outputs SHALL stay combinational during reset.

Configuration
REQ-034 SHALL, with macro BRIDGE_TIMER_EN defined, include the timer of REQ-027..030.
REQ-035 SHALL, with BRIDGE_TIMER_EN undefined, omit all timer logic; 0xFFFFF020 and 0xFFFFF024 SHALL read 0 and ignore writes.

Verification
REQ-036 SHALL cover: write 0x12345678 to 0x00000010, then read 0x00000010 -> dram_we=1 during the write, dram_addr=14'h0004, Bus_rdata=0x12345678.
REQ-037 SHALL cover: write 0x00ABCDEF to 0xFFFFF060 -> led=24'hABCDEF next cycle, dram_we=0, read-back 0x00ABCDEF.
REQ-038 SHALL cover: sw=24'h00F00F -> reading 0xFFFFF070 returns 0x00F00F from the 3rd cycle after the change, old value before that.
REQ-039 SHALL cover: SCAN_DIV=4, seg data 0x0000000A -> dig_en walks FE,FD,...,7F every 4 cycles; seg=8'h88 while dig_en=FE.
REQ-040 SHALL cover: divisor=3 -> count increments every 3 cycles; with count=0xFFFFFFFF it wraps to 0; a count write of 0x100 on a tick cycle reads 0x100.
REQ-041 SHALL cover: cpu_rst asserted mid-scan and mid-timer -> all outputs hold reset values within the same cycle; build without BRIDGE_TIMER_EN -> 0xFFFFF020 reads 0.
